sram_1r1w_arbiter: RTL and testbench

//  Shares one ccs_ram_sync_1R1W SRAM instance between NUM_CLIENTS requesters.

---
 rtl/sram_1r1w_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_1r1w_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_arbiter.sv
// sram_1r1w_arbiter: shares one synchronous 1R1W SRAM between NUM_CLIENTS
// requesters. The write port and the read port each have an independent
// round-robin arbiter. A read and a write that win in the same cycle at the
// same address are a collision. The SRAM never sees a read and a write to one
// address in one cycle, and every collision is counted in coll_cnt.
//
// Build option SRAM_ARB_COLL_FWD_EN:
//   undefined - a colliding read is stalled for one cycle. It is re-arbitrated
//               on the next cycle and returns the freshly written word.
//   defined   - a colliding read is granted without an SRAM access. The write
//               data is captured and returned as the response one cycle later.
//
// Handshake: a transfer happens on the posedge where valid & ready are both
// high. Clients hold valid, addr and data until they are accepted. ready is a
// combinational function of valid and the pointer state, and is held low
// while rst is high. rsp_valid has no backpressure.

module sram_1r1w_arbiter #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_CLIENTS = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            wr_valid,
    output logic [NUM_CLIENTS-1:0]            wr_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_CLIENTS-1:0]            rd_valid,
    output logic [NUM_CLIENTS-1:0]            rd_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              sram_we,
    output logic [ADDR_WIDTH-1:0]             sram_wadr,
    output logic [DATA_WIDTH-1:0]             sram_d,
    output logic                              sram_re,
    output logic [ADDR_WIDTH-1:0]             sram_radr,
    input  logic [DATA_WIDTH-1:0]             sram_q,
    output logic [CNT_WIDTH-1:0]              coll_cnt
);

    localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    // Returns (base + off) mod NUM_CLIENTS. off is always below NUM_CLIENTS.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
        return PTR_W'(s);
    endfunction

    // State
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0]   coll_cnt_q, coll_cnt_d;

    // Arbitration results, before collision and reset gating
    logic [NUM_CLIENTS-1:0] wr_sel, rd_sel;
    logic [PTR_W-1:0]       wr_win, rd_win;
    logic                   wr_any, rd_any;
    logic [ADDR_WIDTH-1:0]  wadr_sel, radr_sel;
    logic [DATA_WIDTH-1:0]  wdata_sel;
    logic                   coll;

    // Round-robin search: the first valid client starting at each pointer wins
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        wr_win = '0;
        rd_win = '0;
        wr_any = 1'b0;
        rd_any = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!wr_any && wr_valid[wrap_idx(wptr_q, i)]) begin
                wr_any = 1'b1;
                wr_win = wrap_idx(wptr_q, i);
            end
            if (!rd_any && rd_valid[wrap_idx(rptr_q, i)]) begin
                rd_any = 1'b1;
                rd_win = wrap_idx(rptr_q, i);
            end
        end
        if (wr_any) wr_sel[wr_win] = 1'b1;
        if (rd_any) rd_sel[rd_win] = 1'b1;
    end

    // Select the winners' address and data. The result is zero when no client is selected.
    always_comb begin
        wadr_sel  = '0;
        wdata_sel = '0;
        radr_sel  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (wr_sel[i]) begin
                wadr_sel  = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_sel[i]) radr_sel = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Grants, collision detection and the SRAM port drive
    always_comb begin
        coll     = !rst && wr_any && rd_any && (wadr_sel == radr_sel);
        wr_ready = rst ? '0 : wr_sel;
`ifdef SRAM_ARB_COLL_FWD_EN
        // The colliding read is granted. The captured write data answers it.
        rd_ready = rst ? '0 : rd_sel;
        sram_re  = (|rd_ready) && !coll;
`else
        // The colliding read waits. The write always goes ahead.
        rd_ready = (rst || coll) ? '0 : rd_sel;
        sram_re  = |rd_ready;
`endif
        sram_we   = |wr_ready;
        sram_wadr = sram_we ? wadr_sel : '0;
        sram_d    = sram_we ? wdata_sel : '0;
        sram_radr = sram_re ? radr_sel : '0;
    end

    // Next-state logic: advance the pointers past each winner, stage the responses, count collisions
    always_comb begin
        wptr_d      = (|wr_ready) ? wrap_idx(wr_win, 1) : wptr_q;
        rptr_d      = (|rd_ready) ? wrap_idx(rd_win, 1) : rptr_q;
        rsp_valid_d = rd_ready;
        coll_cnt_d  = coll_cnt_q;
        if (coll && !(&coll_cnt_q)) coll_cnt_d = coll_cnt_q + 1'b1;
    end

    // State registers. An async reset also drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rsp_valid_q <= '0;
            coll_cnt_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rsp_valid_q <= rsp_valid_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

`ifdef SRAM_ARB_COLL_FWD_EN
    logic                  fwd_sel_q, fwd_sel_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Capture the write data of a collision so it can answer the forwarded read
    always_comb begin
        fwd_sel_d  = coll;
        fwd_data_d = coll ? wdata_sel : fwd_data_q;
    end

    // Forwarding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Response data comes from the forwarded word or from the SRAM
    always_comb begin
        rsp_data = fwd_sel_q ? fwd_data_q : sram_q;
    end
`else
    // Response data comes straight from the SRAM output
    always_comb begin
        rsp_data = sram_q;
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// Bench for sram_1r1w_arbiter: a behavioural SRAM plus a reference model that
// applies the round-robin and collision rules to the client requests. The
// bench checks grants, SRAM port drive, responses and the collision count on
// every cycle.
module tb_sram_1r1w_arbiter;

    localparam int DW = 128;
    localparam int AW = 12;
    localparam int N  = 2;
    localparam int CW = 6;
`ifdef SRAM_ARB_COLL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [N-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [N*AW-1:0] wr_addr, rd_addr;
    logic [N*DW-1:0] wr_data;
    logic [DW-1:0]   rsp_data, sram_d, sram_q;
    logic            sram_we, sram_re;
    logic [AW-1:0]   sram_wadr, sram_radr;
    logic [CW-1:0]   coll_cnt;

    sram_1r1w_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLIENTS(N), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_we(sram_we), .sram_wadr(sram_wadr), .sram_d(sram_d),
        .sram_re(sram_re), .sram_radr(sram_radr), .sram_q(sram_q),
        .coll_cnt(coll_cnt)
    );

    // Behavioural synchronous 1R1W SRAM with a registered read
    logic [DW-1:0] sram_mem [1<<AW];
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_wadr] <= sram_d;
        if (sram_re) sram_q <= sram_mem[sram_radr];
    end

    // ---------------- client request state ----------------
    logic          wv [N];
    logic [AW-1:0] wa [N];
    logic [DW-1:0] wd [N];
    logic          rv [N];
    logic [AW-1:0] ra [N];

    always_comb begin
        wr_valid = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = '0;
        rd_addr  = '0;
        for (int i = 0; i < N; i++) begin
            wr_valid[i]          = wv[i];
            wr_addr[i*AW +: AW]  = wa[i];
            wr_data[i*DW +: DW]  = wd[i];
            rd_valid[i]          = rv[i];
            rd_addr[i*AW +: AW]  = ra[i];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] exp_q[$];
    logic [N-1:0]  exp_rsp_v;
    int            m_wptr, m_rptr, m_coll;
    int            n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_wptr    = 0;
        m_rptr    = 0;
        m_coll    = 0;
        exp_rsp_v = '0;
        exp_q.delete();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            wv[i] = 1'b0; wa[i] = '0; wd[i] = '0; rv[i] = 1'b0; ra[i] = '0;
        end
    endtask

    // One clock cycle. At the falling edge, compare the DUT with the model's
    // view of the current requests. Then advance the model. After the rising
    // edge, drop the requests that were accepted.
    task automatic cycle();
        int           wg, rg;
        bit           col;
        logic [N-1:0] ew, er;
        @(negedge clk);
        wg = -1;
        rg = -1;
        for (int i = 0; i < N; i++) begin
            if (wg < 0 && wv[(m_wptr + i) % N]) wg = (m_wptr + i) % N;
            if (rg < 0 && rv[(m_rptr + i) % N]) rg = (m_rptr + i) % N;
        end
        col = (wg >= 0) && (rg >= 0) && (wa[wg] == ra[rg]);
        if (col && !FWD) rg = -1;
        ew = '0;
        er = '0;
        if (wg >= 0) ew[wg] = 1'b1;
        if (rg >= 0) er[rg] = 1'b1;

        check_eq("rsp_valid", rsp_valid, exp_rsp_v);
        if (exp_rsp_v != '0 && exp_q.size() > 0) check_eq("rsp_data", rsp_data, exp_q.pop_front());
        check_eq("wr_ready", wr_ready, ew);
        check_eq("rd_ready", rd_ready, er);
        check_eq("sram_we", sram_we, wg >= 0);
        check_eq("sram_wadr", sram_wadr, (wg >= 0) ? wa[wg] : '0);
        check_eq("sram_d", sram_d, (wg >= 0) ? wd[wg] : '0);
        check_eq("sram_re", sram_re, (rg >= 0) && !col);
        if (rg >= 0 && !col) check_eq("sram_radr", sram_radr, ra[rg]);
        check_eq("coll_cnt", coll_cnt, m_coll);

        // The model advances by the rising edge that follows this compare
        if (wg >= 0) m_wptr = (wg + 1) % N;
        if (rg >= 0) m_rptr = (rg + 1) % N;
        exp_rsp_v = er;
        if (rg >= 0) exp_q.push_back(col ? wd[wg] : ref_mem[ra[rg]]);
        if (wg >= 0) ref_mem[wa[wg]] = wd[wg];
        if (col && m_coll < CNT_MAX) m_coll++;

        @(posedge clk);
        #1;
        if (wg >= 0) wv[wg] = 1'b0;
        if (rg >= 0) rv[rg] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < (1 << AW); a++) begin
            sram_mem[a] = '0;
            ref_mem[a]  = '0;
        end
        clear_reqs();
        model_reset();

        // Reset state: ready stays low even with every request raised
        for (int i = 0; i < N; i++) begin wv[i] = 1'b1; rv[i] = 1'b1; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wr_ready", wr_ready, '0);
        check_eq("rst_rd_ready", rd_ready, '0);
        check_eq("rst_sram_we", sram_we, 1'b0);
        check_eq("rst_sram_re", sram_re, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, '0);
        check_eq("rst_coll_cnt", coll_cnt, '0);
        clear_reqs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Two writers to one address: client 0 first, then client 1; a read then returns client 1's data
        wv[0] = 1'b1; wa[0] = 12'h010; wd[0] = {32{4'hA}};
        wv[1] = 1'b1; wa[1] = 12'h010; wd[1] = {32{4'hB}};
        cycle();
        cycle();
        rv[0] = 1'b1; ra[0] = 12'h010;
        cycle();
        cycle();

        // Both clients read continuously from different rows, so the grants alternate
        sram_mem[12'h400] = {32{4'h3}};
        ref_mem[12'h400]  = {32{4'h3}};
        for (int k = 0; k < 8; k++) begin
            rv[0] = 1'b1; ra[0] = 12'h000;
            rv[1] = 1'b1; ra[1] = 12'h400;
            cycle();
        end
        clear_reqs();
        cycle();

        // A same-address read and write in one cycle
        wv[0] = 1'b1; wa[0] = 12'h123; wd[0] = {32{4'h5}};
        rv[1] = 1'b1; ra[1] = 12'h123;
        repeat (3) cycle();

        // A read and a write to different addresses in one cycle
        wv[0] = 1'b1; wa[0] = 12'h020; wd[0] = rand_word();
        rv[1] = 1'b1; ra[1] = 12'h021;
        repeat (2) cycle();

        // Random traffic over a narrow address range, so collisions are frequent
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!wv[i] && $urandom_range(0, 99) < 55) begin
                    wv[i] = 1'b1;
                    wa[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 7));
                    wd[i] = rand_word();
                end
                if (!rv[i] && $urandom_range(0, 99) < 55) begin
                    rv[i] = 1'b1;
                    ra[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 7));
                end
            end
            cycle();
        end
        clear_reqs();
        repeat (2) cycle();

        // Force more collisions than the counter can hold
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            wv[0] = 1'b1; wa[0] = 12'h077; wd[0] = rand_word();
            rv[1] = 1'b1; ra[1] = 12'h077;
            cycle();
        end
        clear_reqs();
        repeat (2) cycle();
        check_eq("coll_sat", coll_cnt, CNT_MAX);

        // Reset asserted while a read response is in flight
        wv[0] = 1'b1; wa[0] = 12'h030; wd[0] = rand_word();
        rv[0] = 1'b1; ra[0] = 12'h005;
        cycle();
        #1 rst = 1'b1;
        for (int i = 0; i < N; i++) begin wv[i] = 1'b1; rv[i] = 1'b1; end
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, '0);
        check_eq("midrst_coll_cnt", coll_cnt, '0);
        check_eq("midrst_rd_ready", rd_ready, '0);
        check_eq("midrst_sram_we", sram_we, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            wv[i] = 1'b1; wa[i] = AW'(12'h040 + i); wd[i] = rand_word();
            rv[i] = 1'b1; ra[i] = AW'(12'h050 + i);
        end
        repeat (3) cycle();
        clear_reqs();
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
